// File: rtl/mem2_cp0_stage_if.sv
// Bundle between the execute/memory-stage pipeline, the data memory and the
// MEM2/CP0 stage; master drives instruction and memory-response signals.
interface mem2_cp0_stage_if #(
  parameter int unsigned DW   = 32,
  parameter int unsigned NINT = 6
);
  logic            in_valid;
  logic [3:0]      in_op;
  logic [DW-1:0]   in_pc;
  logic [DW-1:0]   in_addr;
  logic [DW-1:0]   in_wdata;
  logic [DW-1:0]   in_alu;
  logic [4:0]      in_cp0_rd;
  logic [4:0]      in_exc;
  logic            in_bd;
  logic [NINT-1:0] hwint;
  logic            dm_rvalid;
  logic [DW-1:0]   dm_rdata;
  logic            stall;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            exc_req;
  logic            eret;
  logic [DW-1:0]   epc;

  modport master (
    output in_valid, in_op, in_pc, in_addr, in_wdata, in_alu, in_cp0_rd, in_exc, in_bd,
    output hwint, dm_rvalid, dm_rdata,
    input  stall, out_valid, out_data, exc_req, eret, epc
  );

  modport slave (
    input  in_valid, in_op, in_pc, in_addr, in_wdata, in_alu, in_cp0_rd, in_exc, in_bd,
    input  hwint, dm_rvalid, dm_rdata,
    output stall, out_valid, out_data, exc_req, eret, epc
  );
endinterface

// File: rtl/mem2_cp0_stage.sv
// MEM2 pipeline stage: load completion with wait/timeout FSM, load lane
// extraction, and a minimal CP0 (SR, Cause, EPC, PRId) with exception entry/ERET.
module mem2_cp0_stage #(
  parameter int unsigned   DW      = 32,
  parameter int unsigned   NINT    = 6,
  parameter int unsigned   TIMEOUT = 15,
  parameter logic [DW-1:0] PRID    = 32'h0000_0019
) (
  input logic           clk,
  input logic           reset,
  mem2_cp0_stage_if.slave bus
);

  localparam logic [3:0] OpLw   = 4'd1;
  localparam logic [3:0] OpLb   = 4'd2;
  localparam logic [3:0] OpLbu  = 4'd3;
  localparam logic [3:0] OpLh   = 4'd4;
  localparam logic [3:0] OpLhu  = 4'd5;
  localparam logic [3:0] OpMfc0 = 4'd6;
  localparam logic [3:0] OpMtc0 = 4'd7;
  localparam logic [3:0] OpEret = 4'd8;
  localparam logic [3:0] OpAlu  = 4'd9;

  typedef enum logic {StIdle, StWait} state_e;

  state_e          state_q;
  logic [7:0]      cnt_q;
  logic [3:0]      ld_op_q;
  logic [1:0]      ld_addr_q;
  logic [DW-1:0]   ld_pc_q;
  logic            ld_bd_q;
  logic            out_valid_q, exc_req_q, eret_q;
  logic [DW-1:0]   out_data_q;
  logic [NINT-1:0] im_q, ip_q;
  logic            exl_q, ie_q, bd_q;
  logic [4:0]      code_q;
  logic [DW-1:0]   epc_q;

  logic            is_load, int_take, exc_take, exec, timeout;
  logic            ent, ent_bd;
  logic [4:0]      ent_code;
  logic [DW-1:0]   ent_pc, ent_epc;
  logic [DW-1:0]   sr_rd, cause_rd, cp0_rdata, ld_ext;
  logic [3:0]      ext_op;
  logic [1:0]      ext_addr;
  logic [7:0]      ext_b;
  logic [15:0]     ext_h;

  logic unused_addr;
  assign unused_addr = ^bus.in_addr[DW-1:2];

  always_comb begin
    is_load  = (bus.in_op >= OpLw) && (bus.in_op <= OpLhu);
    int_take = bus.in_valid && (state_q == StIdle) && (|(bus.hwint & im_q)) && ie_q && !exl_q;
    exc_take = bus.in_valid && (state_q == StIdle) && !int_take && (bus.in_exc != 5'd0);
    exec     = bus.in_valid && (state_q == StIdle) && !int_take && (bus.in_exc == 5'd0);
    timeout  = (state_q == StWait) && !bus.dm_rvalid && (cnt_q == 8'(TIMEOUT - 1));

    ent      = 1'b0;
    ent_code = 5'd0;
    ent_pc   = bus.in_pc;
    ent_bd   = bus.in_bd;
    if (int_take) begin
      ent = 1'b1;
    end else if (exc_take) begin
      ent      = 1'b1;
      ent_code = bus.in_exc;
    end else if (timeout) begin
      ent      = 1'b1;
      ent_code = 5'd7;
      ent_pc   = ld_pc_q;
      ent_bd   = ld_bd_q;
    end
    ent_epc = ent_bd ? ent_pc - DW'(4) : ent_pc;
  end

  // CP0 read view; bits not backed by state read as zero.
  always_comb begin
    sr_rd              = '0;
    sr_rd[9+NINT:10]   = im_q;
    sr_rd[1]           = exl_q;
    sr_rd[0]           = ie_q;
    cause_rd           = '0;
    cause_rd[31]       = bd_q;
    cause_rd[9+NINT:10] = ip_q;
    cause_rd[6:2]      = code_q;
    case (bus.in_cp0_rd)
      5'd12:   cp0_rdata = sr_rd;
      5'd13:   cp0_rdata = cause_rd;
      5'd14:   cp0_rdata = epc_q;
      5'd15:   cp0_rdata = PRID;
      default: cp0_rdata = '0;
    endcase
  end

  // Load lane extraction; uses the latched load when completing from WAIT.
  always_comb begin
    ext_op   = (state_q == StWait) ? ld_op_q : bus.in_op;
    ext_addr = (state_q == StWait) ? ld_addr_q : bus.in_addr[1:0];
    ext_b    = bus.dm_rdata[{ext_addr, 3'b000} +: 8];
    ext_h    = ext_addr[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
    case (ext_op)
      OpLb:    ld_ext = {{(DW-8){ext_b[7]}}, ext_b};
      OpLbu:   ld_ext = {{(DW-8){1'b0}}, ext_b};
      OpLh:    ld_ext = {{(DW-16){ext_h[15]}}, ext_h};
      OpLhu:   ld_ext = {{(DW-16){1'b0}}, ext_h};
      default: ld_ext = bus.dm_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ld_op_q     <= '0;
      ld_addr_q   <= '0;
      ld_pc_q     <= '0;
      ld_bd_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      exc_req_q   <= 1'b0;
      eret_q      <= 1'b0;
      im_q        <= '0;
      ip_q        <= '0;
      exl_q       <= 1'b0;
      ie_q        <= 1'b0;
      bd_q        <= 1'b0;
      code_q      <= '0;
      epc_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      exc_req_q   <= ent;
      eret_q      <= 1'b0;
      ip_q        <= bus.hwint;
      if (ent) begin
        exl_q  <= 1'b1;
        code_q <= ent_code;
        bd_q   <= ent_bd;
        epc_q  <= ent_epc;
      end
      unique case (state_q)
        StIdle: begin
          if (exec) begin
            if (is_load) begin
              if (bus.dm_rvalid) begin
                out_valid_q <= 1'b1;
                out_data_q  <= ld_ext;
              end else begin
                state_q   <= StWait;
                cnt_q     <= '0;
                ld_op_q   <= bus.in_op;
                ld_addr_q <= bus.in_addr[1:0];
                ld_pc_q   <= bus.in_pc;
                ld_bd_q   <= bus.in_bd;
              end
            end else begin
              case (bus.in_op)
                OpAlu: begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= bus.in_alu;
                end
                OpMfc0: begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= cp0_rdata;
                end
                OpMtc0: begin
                  if (bus.in_cp0_rd == 5'd12) begin
                    im_q  <= bus.in_wdata[9+NINT:10];
                    exl_q <= bus.in_wdata[1];
                    ie_q  <= bus.in_wdata[0];
                  end else if (bus.in_cp0_rd == 5'd14) begin
                    epc_q <= bus.in_wdata;
                  end
                end
                OpEret: begin
                  exl_q  <= 1'b0;
                  eret_q <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        StWait: begin
          if (bus.dm_rvalid) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b1;
            out_data_q  <= ld_ext;
          end else if (timeout) begin
            state_q <= StIdle;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.stall     = (state_q == StWait) && !bus.dm_rvalid;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.exc_req   = exc_req_q;
  assign bus.eret      = eret_q;
  assign bus.epc       = epc_q;

endmodule

// File: tb/tb_mem2_cp0_stage.sv
// Directed-vector bench for mem2_cp0_stage with hand-computed expectations.
module tb_mem2_cp0_stage;

  localparam int unsigned TimeoutCycles = 15;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  mem2_cp0_stage_if #(.DW(32), .NINT(6)) bus ();

  mem2_cp0_stage #(
    .DW(32), .NINT(6), .TIMEOUT(TimeoutCycles), .PRID(32'h0000_0019)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.in_valid  = 1'b0;
    bus.in_op     = 4'd0;
    bus.in_pc     = '0;
    bus.in_addr   = '0;
    bus.in_wdata  = '0;
    bus.in_alu    = '0;
    bus.in_cp0_rd = '0;
    bus.in_exc    = '0;
    bus.in_bd     = 1'b0;
    bus.dm_rvalid = 1'b0;
    bus.dm_rdata  = '0;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input logic [4:0] exc,
                       input logic bd);
    idle_in();
    bus.in_valid  = 1'b1;
    bus.in_op     = op;
    bus.in_pc     = pc;
    bus.in_addr   = addr;
    bus.in_wdata  = wdata;
    bus.in_alu    = wdata;
    bus.in_cp0_rd = rd;
    bus.in_exc    = exc;
    bus.in_bd     = bd;
  endtask

  // Issue MFC0 and check the registered result one cycle later.
  task automatic read_cp0(input string tag, input logic [4:0] rd, input logic [31:0] exp);
    issue(4'd6, 32'h0, 32'h0, 32'h0, rd, 5'd0, 1'b0);
    step();
    check(tag, bus.out_data, exp);
    idle_in();
  endtask

  // Single-cycle load with response in the accept cycle.
  task automatic quick_load(input string tag, input logic [3:0] op, input logic [31:0] addr,
                            input logic [31:0] rdata, input logic [31:0] exp);
    issue(op, 32'h0040_0000, addr, 32'h0, 5'd0, 5'd0, 1'b0);
    bus.dm_rvalid = 1'b1;
    bus.dm_rdata  = rdata;
    #1;
    check({tag, "_stall"}, 32'(bus.stall), 32'd0);
    step();
    check(tag, bus.out_data, exp);
    idle_in();
  endtask

  initial begin
    idle_in();
    bus.hwint = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", bus.out_data, 32'd0);
    check("rst_exc_req", 32'(bus.exc_req), 32'd0);
    check("rst_eret", 32'(bus.eret), 32'd0);
    check("rst_epc", bus.epc, 32'd0);

    // ALU pass-through
    issue(4'd9, 32'h0040_0000, 32'h0, 32'hDEAD_BEEF, 5'd0, 5'd0, 1'b0);
    step();
    check("alu_valid", 32'(bus.out_valid), 32'd1);
    check("alu_data", bus.out_data, 32'hDEAD_BEEF);
    idle_in();
    step();
    check("alu_valid_drop", 32'(bus.out_valid), 32'd0);

    // MTC0 EPC then MFC0 readback, PRId, unimplemented index
    issue(4'd7, 32'h0, 32'h0, 32'h1234_5678, 5'd14, 5'd0, 1'b0);
    step();
    check("mtc0_no_valid", 32'(bus.out_valid), 32'd0);
    check("mtc0_epc", bus.epc, 32'h1234_5678);
    read_cp0("mfc0_epc", 5'd14, 32'h1234_5678);
    read_cp0("mfc0_prid", 5'd15, 32'h0000_0019);
    read_cp0("mfc0_rd3", 5'd3, 32'h0);

    // Zero-wait loads, lane extraction
    quick_load("lw", 4'd1, 32'h0000_1000, 32'hCAFE_F00D, 32'hCAFE_F00D);
    quick_load("lhu_hi", 4'd5, 32'h0000_1002, 32'h80FF_1234, 32'h0000_80FF);
    quick_load("lh_lo", 4'd4, 32'h0000_1000, 32'h0000_8001, 32'hFFFF_8001);
    quick_load("lbu_b1", 4'd3, 32'h0000_1001, 32'h80FF_1234, 32'h0000_0012);

    // LB with two wait cycles
    issue(4'd2, 32'h0040_0004, 32'h0000_2003, 32'h0, 5'd0, 5'd0, 1'b0);
    step();
    idle_in();
    #1 check("lb_stall_w1", 32'(bus.stall), 32'd1);
    step();
    check("lb_stall_w2", 32'(bus.stall), 32'd1);
    check("lb_wait_no_valid", 32'(bus.out_valid), 32'd0);
    step();
    bus.dm_rvalid = 1'b1;
    bus.dm_rdata  = 32'h80FF_1234;
    #1 check("lb_stall_rvalid", 32'(bus.stall), 32'd0);
    step();
    idle_in();
    check("lb_valid", 32'(bus.out_valid), 32'd1);
    check("lb_data", bus.out_data, 32'hFFFF_FF80);
    step();
    check("lb_valid_drop", 32'(bus.out_valid), 32'd0);

    // LW timeout
    issue(4'd1, 32'h0040_0020, 32'h0000_3000, 32'h0, 5'd0, 5'd0, 1'b0);
    step();
    idle_in();
    for (int i = 0; i < int'(TimeoutCycles); i++) begin
      #1 check($sformatf("to_stall_%0d", i), 32'(bus.stall), 32'd1);
      check($sformatf("to_no_exc_%0d", i), 32'(bus.exc_req), 32'd0);
      step();
    end
    check("to_exc_req", 32'(bus.exc_req), 32'd1);
    check("to_epc", bus.epc, 32'h0040_0020);
    check("to_stall_drop", 32'(bus.stall), 32'd0);
    read_cp0("to_cause", 5'd13, 32'h0000_001C);
    check("to_exc_pulse_end", 32'(bus.exc_req), 32'd0);
    bus.dm_rvalid = 1'b1;
    bus.dm_rdata  = 32'h5555_5555;
    step();
    idle_in();
    check("late_rvalid_ignored", 32'(bus.out_valid), 32'd0);
    read_cp0("to_sr_exl", 5'd12, 32'h0000_0002);

    // Interrupt on a delay-slot ALU instruction
    issue(4'd7, 32'h0, 32'h0, 32'h0000_0401, 5'd12, 5'd0, 1'b0);
    step();
    bus.hwint = 6'b000001;
    issue(4'd9, 32'h0040_0010, 32'h0, 32'hAAAA_AAAA, 5'd0, 5'd0, 1'b1);
    step();
    idle_in();
    check("int_exc_req", 32'(bus.exc_req), 32'd1);
    check("int_no_valid", 32'(bus.out_valid), 32'd0);
    check("int_epc", bus.epc, 32'h0040_000C);
    read_cp0("int_cause", 5'd13, 32'h8000_0400);
    read_cp0("int_sr", 5'd12, 32'h0000_0403);

    // ERET, then interrupt wins over in_exc
    issue(4'd8, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    step();
    idle_in();
    check("eret1_pulse", 32'(bus.eret), 32'd1);
    check("eret1_epc", bus.epc, 32'h0040_000C);
    issue(4'd9, 32'h0040_0040, 32'h0, 32'h0, 5'd0, 5'd4, 1'b0);
    step();
    idle_in();
    check("eret_pulse_end", 32'(bus.eret), 32'd0);
    check("intexc_exc_req", 32'(bus.exc_req), 32'd1);
    check("intexc_epc", bus.epc, 32'h0040_0040);
    read_cp0("intexc_cause", 5'd13, 32'h0000_0400);
    issue(4'd8, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 1'b0);
    step();
    idle_in();
    bus.hwint = '0;
    check("eret2_pulse", 32'(bus.eret), 32'd1);
    read_cp0("eret2_sr", 5'd12, 32'h0000_0401);

    // Faulted MTC0 in delay slot: exception wins, no EPC write from wdata
    issue(4'd7, 32'h0000_0100, 32'h0, 32'hFFFF_FFFF, 5'd14, 5'd10, 1'b1);
    step();
    idle_in();
    check("exc_req", 32'(bus.exc_req), 32'd1);
    check("exc_epc", bus.epc, 32'h0000_00FC);
    read_cp0("exc_cause", 5'd13, 32'h8000_0028);

    // Reset during WAIT discards the load
    issue(4'd1, 32'h0040_0080, 32'h0000_4000, 32'h0, 5'd0, 5'd0, 1'b0);
    step();
    idle_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.dm_rvalid = 1'b1;
    bus.dm_rdata  = 32'h7777_7777;
    #1 check("rstw_stall", 32'(bus.stall), 32'd0);
    step();
    idle_in();
    check("rstw_no_valid", 32'(bus.out_valid), 32'd0);
    check("rstw_epc", bus.epc, 32'd0);
    read_cp0("rstw_sr", 5'd12, 32'h0);
    read_cp0("rstw_cause", 5'd13, 32'h0);
    read_cp0("rstw_epc_rd", 5'd14, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
